apb_gpio_slave: RTL and testbench

//   APB completer (slave) with a GPIO register file. It answers the PSEL/PENABLE/PWRITE/PADDR/PWDATA

---
 rtl/apb_gpio_slave.sv | 160 ++++++++++++++++
 tb/tb_apb_gpio_slave.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_slave.sv
// APB completer fronting a small GPIO register file: pin outputs, output enables,
// synchronised inputs and a rising-edge level interrupt.
module apb_gpio_slave #(
   parameter int GPIO_W      = 8,
   parameter int WAIT_STATES = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              pclk,
   input  logic              Reset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [4:0]        paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [GPIO_W-1:0] gpio_oe,
   output logic              irq
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] LAST_CNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       prdata_q, prdata_d;
   logic [GPIO_W-1:0] dataOut_q, dataOut_d;
   logic [GPIO_W-1:0] dir_q, dir_d;
   logic [GPIO_W-1:0] irqEn_q, irqEn_d;
   logic [GPIO_W-1:0] irqStat_q, irqStat_d;
   logic              irq_q, irq_d;
   logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
   logic [GPIO_W-1:0] prev_q;

   logic              access;
   logic              setup;
   logic              commit;
   logic [2:0]        regSel;
   logic [GPIO_W-1:0] wrData;
   logic [GPIO_W-1:0] syncIn;
   logic [GPIO_W-1:0] risingEdge;
   logic [GPIO_W-1:0] w1cMask;
   logic [31:0]       rdMux;
   logic              unusedBits;

   assign access     = psel & penable;
   assign setup      = psel & ~penable;
   assign regSel     = paddr[4:2];
   assign wrData     = pwdata[GPIO_W-1:0];
   assign commit     = (state_q == DONE) & access & pwrite;
   assign syncIn     = sync_q[SYNC_STAGES-1];
   assign risingEdge = syncIn & ~prev_q;
   assign unusedBits = ^{paddr[1:0], pwdata};

   always_comb begin
      rdMux = 32'd0;
      case (regSel)
         3'd0:    rdMux = 32'(dataOut_q);
         3'd1:    rdMux = 32'(dir_q);
         3'd2:    rdMux = 32'(syncIn);
         3'd3:    rdMux = 32'(irqEn_q);
         3'd4:    rdMux = 32'(irqStat_q);
         default: rdMux = 32'd0;
      endcase
   end

   // The setup phase arms the slave so that access cycle 1 already counts as a wait cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prdata_d = prdata_q;
      case (state_q)
         IDLE: begin
            if (setup) begin
               cnt_d = 4'd0;
               if (WAIT_STATES == 0) begin
                  state_d  = DONE;
                  prdata_d = rdMux;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!access) begin
               state_d = IDLE;
            end else if (cnt_q == LAST_CNT) begin
               state_d  = DONE;
               prdata_d = rdMux;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dataOut_d = dataOut_q;
      dir_d     = dir_q;
      irqEn_d   = irqEn_q;
      w1cMask   = '0;
      if (commit) begin
         case (regSel)
            3'd0:    dataOut_d = wrData;
            3'd1:    dir_d     = wrData;
            3'd3:    irqEn_d   = wrData;
            3'd4:    w1cMask   = wrData;
            default: ;
         endcase
      end
      // A fresh edge is OR-ed in after the clear so it survives a simultaneous W1C.
      irqStat_d = (irqStat_q & ~w1cMask) | risingEdge;
      irq_d     = |(irqStat_d & irqEn_d);
   end

   always_ff @(posedge pclk) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         prdata_q  <= 32'd0;
         dataOut_q <= '0;
         dir_q     <= '0;
         irqEn_q   <= '0;
         irqStat_q <= '0;
         irq_q     <= 1'b0;
         prev_q    <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prdata_q  <= prdata_d;
         dataOut_q <= dataOut_d;
         dir_q     <= dir_d;
         irqEn_q   <= irqEn_d;
         irqStat_q <= irqStat_d;
         irq_q     <= irq_d;
         prev_q    <= syncIn;
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign pready   = (state_q == DONE) & access;
   assign prdata   = prdata_q;
   assign gpio_out = dataOut_q;
   assign gpio_oe  = dir_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave: three instances share one APB bus so the
// wait-state variants (1, 3 and 0) can be compared on the same transfer.
module tb_apb_gpio_slave;

   logic        pclk;
   logic        Reset;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [4:0]  paddr;
   logic [31:0] pwdata;
   logic [7:0]  gpioIn;

   logic [31:0] prdata, prdataWs3, prdataWs0;
   logic        pready, preadyWs3, preadyWs0;
   logic [7:0]  gpioOut, gpioOutWs3, gpioOutWs0;
   logic [7:0]  gpioOe, gpioOeWs3, gpioOeWs0;
   logic        irq, irqWs3, irqWs0;

   int vectors;
   int miscompares;

   apb_gpio_slave #(.GPIO_W(8), .WAIT_STATES(1), .SYNC_STAGES(2)) dut (
      .pclk(pclk), .Reset(Reset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .gpio_in(gpioIn), .gpio_out(gpioOut), .gpio_oe(gpioOe), .irq(irq));

   apb_gpio_slave #(.GPIO_W(8), .WAIT_STATES(3), .SYNC_STAGES(2)) dutWs3 (
      .pclk(pclk), .Reset(Reset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdataWs3), .pready(preadyWs3),
      .gpio_in(gpioIn), .gpio_out(gpioOutWs3), .gpio_oe(gpioOeWs3), .irq(irqWs3));

   apb_gpio_slave #(.GPIO_W(8), .WAIT_STATES(0), .SYNC_STAGES(2)) dutWs0 (
      .pclk(pclk), .Reset(Reset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdataWs0), .pready(preadyWs0),
      .gpio_in(gpioIn), .gpio_out(gpioOutWs0), .gpio_oe(gpioOeWs0), .irq(irqWs0));

   // Free-running bus clock.
   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   // Runaway guard so the bench never hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Full APB write on the shared bus, completing on the WAIT_STATES=1 instance.
   task automatic apbWrite(input logic [4:0] addr, input logic [31:0] data, output int cycles);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      @(posedge pclk); #1;
      penable = 1'b1;
      cycles = 1;
      @(negedge pclk);
      while (pready !== 1'b1 && cycles < 20) begin
         @(posedge pclk); #1;
         cycles++;
         @(negedge pclk);
      end
      if (pready !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL write_timeout addr %h: got pready=%b required 1", addr, pready);
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   // Full APB read on the shared bus; data is sampled while pready is high.
   task automatic apbRead(input logic [4:0] addr, output logic [31:0] data, output int cycles);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
      @(posedge pclk); #1;
      penable = 1'b1;
      cycles = 1;
      @(negedge pclk);
      while (pready !== 1'b1 && cycles < 20) begin
         @(posedge pclk); #1;
         cycles++;
         @(negedge pclk);
      end
      data = prdata;
      if (pready !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL read_timeout addr %h: got pready=%b required 1", addr, pready);
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   // Power-on reset, then a reset held two cycles in the middle of a write.
   task automatic test_reset();
      logic [31:0] rd;
      int cyc;
      Reset = 1'b1;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      vectors++;
      if ({prdata, pready, gpioOut, gpioOe, irq} !== 50'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %h required 0", {prdata, pready, gpioOut, gpioOe, irq});
      end
      @(posedge pclk); #1;
      Reset = 1'b0;

      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'h0000_00A5;
      @(posedge pclk); #1;
      penable = 1'b1;
      Reset   = 1'b1;
      @(negedge pclk);
      vectors++;
      if (pready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_midwait_pready: got %b required 0", pready);
      end
      @(posedge pclk); #1;
      @(negedge pclk);
      vectors++;
      if (pready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_held_pready: got %b required 0", pready);
      end
      @(posedge pclk); #1;
      Reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(negedge pclk);
      vectors++;
      if ({prdata, pready, gpioOut, gpioOe, irq} !== 50'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_abort_outputs: got %h required 0", {prdata, pready, gpioOut, gpioOe, irq});
      end
      vectors++;
      if (gpioOutWs0 !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL reset_abort_ws0_dataout: got %h required 00", gpioOutWs0);
      end
      apbRead(5'h00, rd, cyc);
      vectors++;
      if (rd !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_dataout_read: got %h required 00000000", rd);
      end
   endtask

   // Basic register writes/reads, pin outputs and unmapped addresses.
   task automatic test_write_read();
      logic [31:0] rd;
      int cyc;
      apbWrite(5'h00, 32'h0000_00A5, cyc);
      vectors++;
      if (cyc !== 2) begin
         miscompares++;
         $display("[TB] FAIL wr_dataout_latency: got %0d required 2", cyc);
      end
      apbWrite(5'h04, 32'h0000_00FF, cyc);
      vectors++;
      if (cyc !== 2) begin
         miscompares++;
         $display("[TB] FAIL wr_dir_latency: got %0d required 2", cyc);
      end
      vectors++;
      if (gpioOut !== 8'hA5) begin
         miscompares++;
         $display("[TB] FAIL gpio_out: got %h required a5", gpioOut);
      end
      vectors++;
      if (gpioOe !== 8'hFF) begin
         miscompares++;
         $display("[TB] FAIL gpio_oe: got %h required ff", gpioOe);
      end
      apbRead(5'h00, rd, cyc);
      vectors++;
      if (rd !== 32'h0000_00A5) begin
         miscompares++;
         $display("[TB] FAIL rd_dataout: got %h required 000000a5", rd);
      end
      vectors++;
      if (cyc !== 2) begin
         miscompares++;
         $display("[TB] FAIL rd_latency: got %0d required 2", cyc);
      end
      apbRead(5'h06, rd, cyc);
      vectors++;
      if (rd !== 32'h0000_00FF) begin
         miscompares++;
         $display("[TB] FAIL rd_dir_lowbits_ignored: got %h required 000000ff", rd);
      end
      apbRead(5'h18, rd, cyc);
      vectors++;
      if (rd !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL rd_unmapped: got %h required 00000000", rd);
      end
      apbWrite(5'h1C, 32'h0000_0011, cyc);
      apbRead(5'h00, rd, cyc);
      vectors++;
      if (rd !== 32'h0000_00A5 || gpioOut !== 8'hA5) begin
         miscompares++;
         $display("[TB] FAIL wr_unmapped_ignored: got %h/%h required 000000a5/a5", rd, gpioOut);
      end
   endtask

   // One read held in access phase for five cycles, watching pready on the WS=3 and WS=0 slaves.
   task automatic test_wait_states();
      logic [4:0] expWs3;
      logic [4:0] expWs0;
      expWs3 = 5'b01000;
      expWs0 = 5'b00001;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 5'h00;
      @(posedge pclk); #1;
      penable = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge pclk);
         vectors++;
         if (preadyWs3 !== expWs3[c]) begin
            miscompares++;
            $display("[TB] FAIL ws3_pready_cycle%0d: got %b required %b", c + 1, preadyWs3, expWs3[c]);
         end
         vectors++;
         if (preadyWs0 !== expWs0[c]) begin
            miscompares++;
            $display("[TB] FAIL ws0_pready_cycle%0d: got %b required %b", c + 1, preadyWs0, expWs0[c]);
         end
         if (c == 0) begin
            vectors++;
            if (prdataWs0 !== 32'h0000_00A5) begin
               miscompares++;
               $display("[TB] FAIL ws0_prdata: got %h required 000000a5", prdataWs0);
            end
         end
         if (c == 3) begin
            vectors++;
            if (prdataWs3 !== 32'd0) begin
               miscompares++;
               $display("[TB] FAIL ws3_prdata: got %h required 00000000", prdataWs3);
            end
         end
         @(posedge pclk); #1;
      end
      psel = 1'b0; penable = 1'b0;
   endtask

   // Bridge drops psel while the slave is waiting: no completion, no write.
   task automatic test_abort();
      logic [31:0] rd;
      int cyc;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h0C; pwdata = 32'h0000_003C;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge pclk);
         vectors++;
         if (pready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_pready_cycle%0d: got %b required 0", c, pready);
         end
         @(posedge pclk); #1;
         penable = 1'b0; pwrite = 1'b0;
      end
      apbRead(5'h0C, rd, cyc);
      vectors++;
      if (rd !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL abort_irq_en: got %h required 00000000", rd);
      end
   endtask

   // Rising edge on pin 0 sets IRQ_STAT and irq; W1C clears; a falling edge flags nothing.
   task automatic test_input_irq();
      logic [31:0] rd;
      int cyc;
      apbWrite(5'h0C, 32'h0000_0001, cyc);
      @(posedge pclk); #1;
      gpioIn = 8'h01;
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      @(negedge pclk);
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL irq_too_early: got %b required 0", irq);
      end
      @(posedge pclk); #1;
      @(negedge pclk);
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL irq_after_edge: got %b required 1", irq);
      end
      apbRead(5'h08, rd, cyc);
      vectors++;
      if (rd !== 32'h0000_0001) begin
         miscompares++;
         $display("[TB] FAIL data_in_high: got %h required 00000001", rd);
      end
      apbRead(5'h10, rd, cyc);
      vectors++;
      if (rd !== 32'h0000_0001) begin
         miscompares++;
         $display("[TB] FAIL irq_stat_set: got %h required 00000001", rd);
      end
      apbWrite(5'h10, 32'h0000_0001, cyc);
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL irq_after_w1c: got %b required 0", irq);
      end
      apbRead(5'h10, rd, cyc);
      vectors++;
      if (rd !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL irq_stat_cleared: got %h required 00000000", rd);
      end
      gpioIn = 8'h00;
      repeat (5) @(posedge pclk);
      #1;
      apbRead(5'h10, rd, cyc);
      vectors++;
      if (rd !== 32'd0 || irq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL falling_edge_flag: got stat %h irq %b required 00000000 0", rd, irq);
      end
      apbRead(5'h08, rd, cyc);
      vectors++;
      if (rd !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL data_in_low: got %h required 00000000", rd);
      end
   endtask

   // W1C of bit 0 in the very cycle a new edge on bit 0 reaches the edge detector.
   task automatic test_collision();
      logic [31:0] rd;
      int cyc;
      gpioIn = 8'h01;
      repeat (4) @(posedge pclk);
      #1;
      gpioIn = 8'h00;
      repeat (4) @(posedge pclk);
      #1;
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL collision_precondition_irq: got %b required 1", irq);
      end
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h10; pwdata = 32'h0000_0001;
      gpioIn = 8'h01;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      vectors++;
      if (pready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL collision_wait_pready: got %b required 0", pready);
      end
      @(posedge pclk); #1;
      @(negedge pclk);
      vectors++;
      if (pready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL collision_done_pready: got %b required 1", pready);
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      apbRead(5'h10, rd, cyc);
      vectors++;
      if (rd !== 32'h0000_0001 || irq !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL collision_edge_wins: got stat %h irq %b required 00000001 1", rd, irq);
      end
      apbRead(5'h08, rd, cyc);
      vectors++;
      if (rd !== 32'h0000_0001) begin
         miscompares++;
         $display("[TB] FAIL data_in_with_dir_out: got %h required 00000001", rd);
      end
      apbWrite(5'h00, 32'hFFFF_FF00, cyc);
      vectors++;
      if (gpioOut !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL upper_bits_gpio_out: got %h required 00", gpioOut);
      end
      apbRead(5'h00, rd, cyc);
      vectors++;
      if (rd !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL upper_bits_read: got %h required 00000000", rd);
      end
   endtask

   // Scenario sequence.
   initial begin
      vectors     = 0;
      miscompares = 0;
      Reset   = 1'b1;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 5'h00;
      pwdata  = 32'd0;
      gpioIn  = 8'h00;
      test_reset();
      test_write_read();
      test_wait_states();
      test_abort();
      test_input_irq();
      test_collision();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
